// File: rtl/weapons_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weapons_pkg
// Description : Shared types and constants for the weapon fire scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package weapons_pkg;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FIRE     = 2'd1,
        S_COOLDOWN = 2'd2,
        S_RELOAD   = 2'd3
    } state_t;

    // One-hot mode_selector code that enables firing
    localparam logic [3:0] ATTACK_MODE = 4'b0010;

    // Default magazine capacity
    localparam int DEFAULT_MAX_AMMO = 500;

endpackage
`default_nettype wire

// File: rtl/weapon_fire_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The lowest requesting
//               index at or after ptr (wrapping) wins; output is one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    // Scan from the pointer upward with wrap; first requester found wins
    always_comb begin
        logic             w_found;
        logic [PTR_W-1:0] w_idx;
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/weapon_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : weapon_fire_scheduler
// Description : Registered controller for a shared ammunition magazine:
//               attack-mode gating, round-robin turret arbitration, per-shot
//               round metering, post-shot cooldown and reload sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module weapon_fire_scheduler
    import weapons_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int AMMO_W     = 9,
    parameter int MAX_AMMO   = DEFAULT_MAX_AMMO,
    parameter int COOLDOWN   = 2,
    parameter int RELOAD_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mode_selector,
    input  logic [N_REQ-1:0]  req,
    input  logic [AMMO_W-1:0] fire_rate,
    input  logic              reload_req,
    input  logic [AMMO_W-1:0] reload_amt,
    output logic [N_REQ-1:0]  grant,
    output logic              shot_valid,
    output logic [AMMO_W-1:0] shot_count,
    output logic [AMMO_W-1:0] ammo,
    output logic              reloading,
    output logic              error
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    localparam logic [CNT_W-1:0] RL_LAST = CNT_W'((RELOAD_CYC > 1) ? RELOAD_CYC - 1 : 0);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_win_idx;
    logic              r_pending;
    logic [AMMO_W-1:0] r_ammo;
    logic [N_REQ-1:0]  r_grant;
    logic              r_shot_valid;
    logic [AMMO_W-1:0] r_shot_count;
    logic              r_reloading;
    logic              r_error;

    logic [N_REQ-1:0]  w_win;
    logic [PTR_W-1:0]  w_win_idx;
    logic [PTR_W-1:0]  w_next_ptr;
    logic [AMMO_W-1:0] w_eff_rate;
    logic [AMMO_W-1:0] w_shot;
    logic [AMMO_W:0]   w_sum;
    logic [AMMO_W-1:0] w_reload_ammo;
    logic              w_attack;
    logic              w_can_fire;
    logic              w_eval;
    logic              w_err;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_win)
    );

    // Encode the one-hot winner to an index for the pointer update
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) w_win_idx = PTR_W'(i);
        end
    end

    // Shot metering, reload saturation and error qualification
    always_comb begin
        w_next_ptr    = (r_win_idx == PTR_W'(N_REQ - 1)) ? '0 : r_win_idx + PTR_W'(1);
        w_eff_rate    = (fire_rate == '0) ? AMMO_W'(1) : fire_rate;
        w_shot        = (w_eff_rate < r_ammo) ? w_eff_rate : r_ammo;
        w_sum         = {1'b0, r_ammo} + {1'b0, reload_amt};
        w_reload_ammo = (w_sum > (AMMO_W+1)'(MAX_AMMO)) ? AMMO_W'(MAX_AMMO) : w_sum[AMMO_W-1:0];
        w_attack      = (mode_selector == ATTACK_MODE);
        w_can_fire    = (|req) && w_attack && (r_ammo != '0);
        // The idle decision is also taken on the final cooldown edge, so
        // consecutive shots are exactly FIRE plus COOLDOWN cycles apart.
        w_eval        = (r_state == S_IDLE) ||
                        ((r_state == S_COOLDOWN) && (r_cnt == CD_LAST));
        w_err         = (|req) &&
                        (((r_state == S_IDLE) &&
                          (!w_attack || ((r_ammo == '0) && !reload_req && !r_pending))) ||
                         (r_state == S_RELOAD));
    end

    // Main controller: state, counters, magazine and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_win_idx    <= '0;
            r_pending    <= 1'b0;
            r_ammo       <= '0;
            r_grant      <= '0;
            r_shot_valid <= 1'b0;
            r_shot_count <= '0;
            r_reloading  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_error      <= w_err;
            r_grant      <= '0;
            r_shot_valid <= 1'b0;
            r_shot_count <= '0;
            r_reloading  <= 1'b0;
            if (w_eval) begin
                if (reload_req || r_pending) begin
                    r_state     <= S_RELOAD;
                    r_pending   <= 1'b0;
                    r_cnt       <= '0;
                    r_reloading <= 1'b1;
                end else if (w_can_fire) begin
                    r_state      <= S_FIRE;
                    r_grant      <= w_win;
                    r_shot_valid <= 1'b1;
                    r_shot_count <= w_shot;
                    r_win_idx    <= w_win_idx;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_FIRE: begin
                        r_ammo <= r_ammo - r_shot_count;
                        r_ptr  <= w_next_ptr;
                        r_cnt  <= '0;
                        if (reload_req) r_pending <= 1'b1;
                        r_state <= (COOLDOWN > 0) ? S_COOLDOWN : S_IDLE;
                    end
                    S_COOLDOWN: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (reload_req) r_pending <= 1'b1;
                    end
                    S_RELOAD: begin
                        if (r_cnt == RL_LAST) begin
                            r_ammo  <= w_reload_ammo;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt       <= r_cnt + CNT_W'(1);
                            r_reloading <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign grant      = r_grant;
    assign shot_valid = r_shot_valid;
    assign shot_count = r_shot_count;
    assign ammo       = r_ammo;
    assign reloading  = r_reloading;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_weapon_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_weapon_fire_scheduler
// Description : Directed self-checking bench for weapon_fire_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weapon_fire_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] mode_selector;
    logic [3:0] req;
    logic [8:0] fire_rate;
    logic       reload_req;
    logic [8:0] reload_amt;
    logic [3:0] grant;
    logic       shot_valid;
    logic [8:0] shot_count;
    logic [8:0] ammo;
    logic       reloading;
    logic       error;

    int total = 0;
    int bad   = 0;

    weapon_fire_scheduler #(
        .N_REQ      (4),
        .AMMO_W     (9),
        .MAX_AMMO   (500),
        .COOLDOWN   (2),
        .RELOAD_CYC (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_selector (mode_selector),
        .req           (req),
        .fire_rate     (fire_rate),
        .reload_req    (reload_req),
        .reload_amt    (reload_amt),
        .grant         (grant),
        .shot_valid    (shot_valid),
        .shot_count    (shot_count),
        .ammo          (ammo),
        .reloading     (reloading),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; req = '0; reload_req = 1'b0; mode_selector = 4'b0000;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic do_reload(input logic [8:0] amt);
        reload_amt = amt; reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; mode_selector = '0; req = '0; fire_rate = '0;
        reload_req = 1'b0; reload_amt = '0;
        #1;
        total++; if (grant !== 4'b0)      begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL reset_shot_valid got=%b exp=0", shot_valid); end
        total++; if (shot_count !== 9'd0) begin bad++; $display("FAIL reset_shot_count got=%0d exp=0", shot_count); end
        total++; if (ammo !== 9'd0)       begin bad++; $display("FAIL reset_ammo got=%0d exp=0", ammo); end
        total++; if (reloading !== 1'b0)  begin bad++; $display("FAIL reset_reloading got=%b exp=0", reloading); end
        total++; if (error !== 1'b0)      begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reload();
        reload_amt = 9'd500; reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (reloading !== 1'b1) begin bad++; $display("FAIL reload_busy[%0d] got=%b exp=1", i, reloading); end
            total++; if (ammo !== 9'd0)      begin bad++; $display("FAIL reload_ammo_hold[%0d] got=%0d exp=0", i, ammo); end
            tick();
        end
        total++; if (reloading !== 1'b0) begin bad++; $display("FAIL reload_done got=%b exp=0", reloading); end
        total++; if (ammo !== 9'd500)    begin bad++; $display("FAIL reload_ammo got=%0d exp=500", ammo); end
    endtask

    task automatic test_single_shot();
        mode_selector = 4'b0010; fire_rate = 9'd5; req = 4'b0001;
        tick();
        total++; if (grant !== 4'b0001)   begin bad++; $display("FAIL shot_grant got=%b exp=0001", grant); end
        total++; if (shot_valid !== 1'b1) begin bad++; $display("FAIL shot_valid got=%b exp=1", shot_valid); end
        total++; if (shot_count !== 9'd5) begin bad++; $display("FAIL shot_count got=%0d exp=5", shot_count); end
        tick();
        total++; if (grant !== 4'b0000)   begin bad++; $display("FAIL shot_cd1_grant got=%b exp=0000", grant); end
        total++; if (ammo !== 9'd495)     begin bad++; $display("FAIL shot_ammo got=%0d exp=495", ammo); end
        tick();
        total++; if (grant !== 4'b0000)   begin bad++; $display("FAIL shot_cd2_grant got=%b exp=0000", grant); end
        total++; if (error !== 1'b0)      begin bad++; $display("FAIL shot_cd_error got=%b exp=0", error); end
        tick();
        total++; if (grant !== 4'b0001)   begin bad++; $display("FAIL shot_regrant got=%b exp=0001", grant); end
        req = 4'b0000;
        tick();
        total++; if (ammo !== 9'd490)     begin bad++; $display("FAIL shot_ammo2 got=%0d exp=490", ammo); end
        tick(); tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        do_reload(9'd500);
        mode_selector = 4'b0010; fire_rate = 9'd1; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (grant !== exp_g[i]) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant, exp_g[i]); end
            total++; if (shot_count !== 9'd1) begin bad++; $display("FAIL rr_count[%0d] got=%0d exp=1", i, shot_count); end
            tick();
            total++; if (grant !== 4'b0000)  begin bad++; $display("FAIL rr_gap1[%0d] got=%b exp=0000", i, grant); end
            tick();
            total++; if (grant !== 4'b0000)  begin bad++; $display("FAIL rr_gap2[%0d] got=%b exp=0000", i, grant); end
        end
        req = 4'b0000;
        tick();
        total++; if (ammo !== 9'd495) begin bad++; $display("FAIL rr_ammo got=%0d exp=495", ammo); end
    endtask

    task automatic test_underflow_empty();
        apply_reset();
        do_reload(9'd3);
        mode_selector = 4'b0010; fire_rate = 9'd5; req = 4'b0001;
        tick();
        total++; if (shot_count !== 9'd3) begin bad++; $display("FAIL uf_count got=%0d exp=3", shot_count); end
        req = 4'b0000;
        tick();
        total++; if (ammo !== 9'd0) begin bad++; $display("FAIL uf_ammo got=%0d exp=0", ammo); end
        tick(); tick();
        req = 4'b0001;
        tick();
        total++; if (error !== 1'b1)      begin bad++; $display("FAIL empty_error got=%b exp=1", error); end
        total++; if (grant !== 4'b0000)   begin bad++; $display("FAIL empty_grant got=%b exp=0000", grant); end
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b exp=0", shot_valid); end
        req = 4'b0000;
        tick();
        total++; if (error !== 1'b0) begin bad++; $display("FAIL empty_error_clear got=%b exp=0", error); end
        do_reload(9'd10);
        fire_rate = 9'd0; req = 4'b0001;
        tick();
        total++; if (shot_count !== 9'd1) begin bad++; $display("FAIL rate0_count got=%0d exp=1", shot_count); end
        total++; if (grant !== 4'b0001)   begin bad++; $display("FAIL rate0_grant got=%b exp=0001", grant); end
        req = 4'b0000;
        tick();
        total++; if (ammo !== 9'd9) begin bad++; $display("FAIL rate0_ammo got=%0d exp=9", ammo); end
        tick(); tick();
    endtask

    task automatic test_wrong_mode();
        apply_reset();
        do_reload(9'd100);
        mode_selector = 4'b0001; fire_rate = 9'd1; req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (error !== 1'b1)    begin bad++; $display("FAIL mode_error[%0d] got=%b exp=1", i, error); end
            total++; if (grant !== 4'b0000) begin bad++; $display("FAIL mode_grant[%0d] got=%b exp=0000", i, grant); end
        end
        req = 4'b0000;
        tick();
        total++; if (error !== 1'b0)  begin bad++; $display("FAIL mode_error_clear got=%b exp=0", error); end
        total++; if (ammo !== 9'd100) begin bad++; $display("FAIL mode_ammo got=%0d exp=100", ammo); end
    endtask

    task automatic test_saturation();
        apply_reset();
        do_reload(9'd450);
        total++; if (ammo !== 9'd450) begin bad++; $display("FAIL sat_first got=%0d exp=450", ammo); end
        do_reload(9'd200);
        total++; if (ammo !== 9'd500) begin bad++; $display("FAIL sat_clamp got=%0d exp=500", ammo); end
    endtask

    task automatic test_pending_reload();
        mode_selector = 4'b0010; fire_rate = 9'd3; req = 4'b0001;
        tick();
        total++; if (shot_count !== 9'd3) begin bad++; $display("FAIL pend_count got=%0d exp=3", shot_count); end
        req = 4'b0000;
        tick();
        total++; if (ammo !== 9'd497) begin bad++; $display("FAIL pend_ammo got=%0d exp=497", ammo); end
        reload_req = 1'b1; reload_amt = 9'd2;
        tick();
        reload_req = 1'b0;
        total++; if (reloading !== 1'b0) begin bad++; $display("FAIL pend_in_cd got=%b exp=0", reloading); end
        tick();
        total++; if (reloading !== 1'b1) begin bad++; $display("FAIL pend_enter got=%b exp=1", reloading); end
        tick(); tick(); tick();
        total++; if (reloading !== 1'b0) begin bad++; $display("FAIL pend_done got=%b exp=0", reloading); end
        total++; if (ammo !== 9'd499)    begin bad++; $display("FAIL pend_ammo_final got=%0d exp=499", ammo); end
    endtask

    task automatic test_async_reset();
        reload_amt = 9'd1; reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        tick();
        total++; if (reloading !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b exp=1", reloading); end
        #2 rst = 1'b0;
        #1;
        total++; if (ammo !== 9'd0)      begin bad++; $display("FAIL areset_ammo got=%0d exp=0", ammo); end
        total++; if (reloading !== 1'b0) begin bad++; $display("FAIL areset_reloading got=%b exp=0", reloading); end
        tick();
        rst = 1'b1;
        tick();
        total++; if (ammo !== 9'd0)      begin bad++; $display("FAIL areset_after_ammo got=%0d exp=0", ammo); end
        total++; if (reloading !== 1'b0) begin bad++; $display("FAIL areset_after_rl got=%b exp=0", reloading); end
    endtask

    initial begin
        test_reset();
        test_reload();
        test_single_shot();
        test_round_robin();
        test_underflow_empty();
        test_wrong_mode();
        test_saturation();
        test_pending_reload();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
